// File: rtl/cnt_monitor.sv
// cnt_monitor: passive checker for a decade up/down counter with sticky error flags and a saturating error count.
module cnt_monitor #(
   parameter int CNT_W    = 4,
   parameter int CNT_MAX  = 9,
   parameter int STEP_BIG = 3,
   parameter int ERRC_W   = 8
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Obs_Rst,
   input  logic              Obs_En,
   input  logic              Obs_Mode,
   input  logic              Obs_Step,
   input  logic [CNT_W-1:0]  Obs_Cnt,
   input  logic              Clear,
   output logic              Chk_Valid,
   output logic              Reset_Err,
   output logic              Count_Err,
   output logic              Range_Err,
   output logic              Wrap_Pulse,
   output logic [ERRC_W-1:0] Err_Cnt,
   output logic              Test_Err
);
   localparam logic [CNT_W:0] MAXV = (CNT_W+1)'(CNT_MAX);
   localparam logic [CNT_W:0] MODV = (CNT_W+1)'(CNT_MAX + 1);
   localparam logic [CNT_W:0] BIGV = (CNT_W+1)'(STEP_BIG);
   localparam logic [CNT_W:0] ONEV = (CNT_W+1)'(1);
   typedef enum logic {IDLE, TRACK} state_t;
   state_t state;
   logic p_rst, p_en, p_mode, p_step;
   logic [CNT_W-1:0] p_cnt;
   logic [CNT_W:0] pc, s, up, pred;
   logic track, borrow, undef, rst_mis, cnt_mis, rng_mis, wrap_hit;
   // prediction is carried one bit wider so the up-sum and down-borrow never overflow
   always_comb begin
      track    = state == TRACK;
      pc       = {1'b0, p_cnt};
      s        = p_step ? BIGV : ONEV;
      up       = pc + s;
      borrow   = pc < s;
      pred     = !p_en ? pc : p_mode ? (up > MAXV ? up - MODV : up) : (borrow ? pc + MODV - s : pc - s);
      undef    = !p_rst && pc > MAXV;
      rst_mis  = p_rst && Obs_Cnt != '0;
      cnt_mis  = !p_rst && !undef && {1'b0, Obs_Cnt} != pred;
      rng_mis  = {1'b0, Obs_Cnt} > MAXV || undef;
      wrap_hit = track && !p_rst && p_en && !undef && (p_mode ? up > MAXV : borrow);
   end
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state      <= IDLE;
         p_rst      <= 1'b0;
         p_en       <= 1'b0;
         p_mode     <= 1'b0;
         p_step     <= 1'b0;
         p_cnt      <= '0;
         Reset_Err  <= 1'b0;
         Count_Err  <= 1'b0;
         Range_Err  <= 1'b0;
         Wrap_Pulse <= 1'b0;
         Err_Cnt    <= '0;
      end else begin
         state      <= TRACK;
         p_rst      <= Obs_Rst;
         p_en       <= Obs_En;
         p_mode     <= Obs_Mode;
         p_step     <= Obs_Step;
         p_cnt      <= Obs_Cnt;
         Wrap_Pulse <= wrap_hit;
         if (Clear) begin
            Reset_Err <= 1'b0;
            Count_Err <= 1'b0;
            Range_Err <= 1'b0;
            Err_Cnt   <= '0;
         end else if (track) begin
            Reset_Err <= Reset_Err | rst_mis;
            Count_Err <= Count_Err | cnt_mis;
            Range_Err <= Range_Err | rng_mis;
            if ((rst_mis | cnt_mis | rng_mis) && !(&Err_Cnt)) Err_Cnt <= Err_Cnt + 1'b1;
         end
      end
   end
   assign Chk_Valid = track;
   assign Test_Err  = Reset_Err | Count_Err | Range_Err;
endmodule

// File: tb/tb_cnt_monitor.sv
// tb_cnt_monitor: directed scenarios plus random traffic, checked every cycle against an arithmetic model of the counter rules.
module tb_cnt_monitor;
   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic       Obs_Rst = 1'b0, Obs_En = 1'b0, Obs_Mode = 1'b0, Obs_Step = 1'b0, Clear = 1'b0;
   logic [3:0] Obs_Cnt = 4'd0;
   logic       Chk_Valid, Reset_Err, Count_Err, Range_Err, Wrap_Pulse, Test_Err;
   logic [7:0] Err_Cnt;
   int checks = 0, failures = 0;
   int c = 0;
   int wraps;
   bit go = 0;
   bit m_trk = 0, e_rst = 0, e_cnt = 0, e_rng = 0, e_wrap = 0;
   int pr = 0, pe = 0, pm = 0, ps = 0, pc = 0, e_err = 0;

   cnt_monitor dut (
      .Clk(Clk), .Rst(Rst), .Obs_Rst(Obs_Rst), .Obs_En(Obs_En), .Obs_Mode(Obs_Mode),
      .Obs_Step(Obs_Step), .Obs_Cnt(Obs_Cnt), .Clear(Clear), .Chk_Valid(Chk_Valid),
      .Reset_Err(Reset_Err), .Count_Err(Count_Err), .Range_Err(Range_Err),
      .Wrap_Pulse(Wrap_Pulse), .Err_Cnt(Err_Cnt), .Test_Err(Test_Err)
   );

   always #5 Clk = ~Clk;

   function automatic int nxt(int en, int mode, int stp, int cur);
      int st = stp ? 3 : 1;
      return !en ? cur : mode ? (cur + st) % 10 : (cur + 10 - st) % 10;
   endfunction

   function automatic bit wraps_of(int r, int en, int mode, int stp, int cur);
      int st = stp ? 3 : 1;
      return !r && en && cur <= 9 && (mode ? cur + st > 9 : cur < st);
   endfunction

   function automatic bit mis_rst(int r, int cnt);
      return r != 0 && cnt != 0;
   endfunction

   function automatic bit mis_cnt(int r, int en, int mode, int stp, int cur, int cnt);
      return !r && cur <= 9 && cnt != nxt(en, mode, stp, cur);
   endfunction

   function automatic bit mis_rng(int r, int cur, int cnt);
      return cnt > 9 || (!r && cur > 9);
   endfunction

   // reference model: prediction from the previous observation, flags one edge later
   always @(posedge Clk) begin
      if (Rst) begin
         m_trk <= 0; pr <= 0; pe <= 0; pm <= 0; ps <= 0; pc <= 0;
         e_rst <= 0; e_cnt <= 0; e_rng <= 0; e_wrap <= 0; e_err <= 0;
      end else begin
         m_trk <= 1; pr <= int'(Obs_Rst); pe <= int'(Obs_En); pm <= int'(Obs_Mode);
         ps <= int'(Obs_Step); pc <= int'(Obs_Cnt);
         e_wrap <= m_trk && wraps_of(pr, pe, pm, ps, pc);
         if (Clear) begin
            e_rst <= 0; e_cnt <= 0; e_rng <= 0; e_err <= 0;
         end else if (m_trk) begin
            e_rst <= e_rst | mis_rst(pr, int'(Obs_Cnt));
            e_cnt <= e_cnt | mis_cnt(pr, pe, pm, ps, pc, int'(Obs_Cnt));
            e_rng <= e_rng | mis_rng(pr, pc, int'(Obs_Cnt));
            if (mis_rst(pr, int'(Obs_Cnt)) || mis_cnt(pr, pe, pm, ps, pc, int'(Obs_Cnt)) ||
                mis_rng(pr, pc, int'(Obs_Cnt)))
               e_err <= (e_err >= 255) ? 255 : e_err + 1;
         end
      end
   end

   task automatic cmp(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   always @(negedge Clk) begin
      if (go) begin
         cmp("chk_valid", int'(Chk_Valid), int'(m_trk));
         cmp("reset_err", int'(Reset_Err), int'(e_rst));
         cmp("count_err", int'(Count_Err), int'(e_cnt));
         cmp("range_err", int'(Range_Err), int'(e_rng));
         cmp("wrap_pulse", int'(Wrap_Pulse), int'(e_wrap));
         cmp("err_cnt", int'(Err_Cnt), e_err);
         cmp("test_err", int'(Test_Err), int'(e_rst | e_cnt | e_rng));
      end
   end

   task automatic cyc(input bit rst, input bit orst, input bit en, input bit mode, input bit stp,
                      input bit clr, input int cnt);
      Rst = rst; Obs_Rst = orst; Obs_En = en; Obs_Mode = mode; Obs_Step = stp; Clear = clr;
      Obs_Cnt = 4'(cnt);
      @(posedge Clk);
      #2;
      c = orst ? 0 : (cnt > 9 ? 0 : nxt(int'(en), int'(mode), int'(stp), cnt));
   endtask

   initial begin
      cyc(1, 0, 0, 0, 0, 0, 0);
      go = 1;
      cmp("rst_chk_valid", int'(Chk_Valid), 0);
      cmp("rst_err_cnt", int'(Err_Cnt), 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      c = 0;
      // correct up count by 1 through a wrap
      wraps = 0;
      for (int i = 0; i < 12; i++) begin
         cyc(0, 0, 1, 1, 0, 0, c);
         if (i == 0) cmp("valid_after_idle", int'(Chk_Valid), 1);
         wraps += int'(Wrap_Pulse);
      end
      cmp("up_wraps", wraps, 1);
      cmp("up_err_cnt", int'(Err_Cnt), 0);
      cmp("up_test_err", int'(Test_Err), 0);
      // correct down count by STEP_BIG from 2: 2,9,6,3
      cmp("down_start", c, 2);
      wraps = 0;
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 1, 0, 1, 0, c);
         wraps += int'(Wrap_Pulse);
      end
      cmp("down_wraps", wraps, 1);
      cmp("down_err_cnt", int'(Err_Cnt), 0);
      // observed reset held two cycles, counter fails to clear on the first
      cyc(0, 1, 1, 0, 1, 0, c);
      cyc(0, 1, 0, 0, 0, 0, 5);
      cyc(0, 0, 0, 0, 0, 0, 0);
      cmp("orst_reset_err", int'(Reset_Err), 1);
      cmp("orst_count_err", int'(Count_Err), 0);
      cmp("orst_err_cnt", int'(Err_Cnt), 1);
      cmp("orst_test_err", int'(Test_Err), 1);
      // hold violation, then clear
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 0, 0, c);
      cyc(0, 0, 0, 0, 0, 0, 4);
      cyc(0, 0, 0, 0, 0, 0, 5);
      cmp("hold_count_err", int'(Count_Err), 1);
      cmp("hold_err_cnt", int'(Err_Cnt), 2);
      cyc(0, 0, 0, 0, 0, 1, 5);
      cmp("clear_test_err", int'(Test_Err), 0);
      cmp("clear_err_cnt", int'(Err_Cnt), 0);
      // out-of-range value right after an observed reset
      cyc(0, 1, 0, 0, 0, 0, 5);
      cyc(0, 0, 1, 1, 0, 0, 12);
      cmp("range_err", int'(Range_Err), 1);
      cmp("range_no_count", int'(Count_Err), 0);
      cyc(0, 0, 1, 1, 0, 0, 0);
      cmp("undef_no_count", int'(Count_Err), 0);
      cmp("undef_range", int'(Range_Err), 1);
      // saturate the error counter
      cyc(0, 0, 1, 1, 0, 1, c);
      for (int i = 0; i < 300; i++) cyc(0, 0, 0, 0, 0, 0, (i % 2) ? 3 : 7);
      cmp("sat_err_cnt", int'(Err_Cnt), 255);
      cmp("sat_count_err", int'(Count_Err), 1);
      cyc(1, 0, 0, 0, 0, 0, 7);
      cmp("mid_rst_valid", int'(Chk_Valid), 0);
      cmp("mid_rst_err_cnt", int'(Err_Cnt), 0);
      cmp("mid_rst_test_err", int'(Test_Err), 0);
      cyc(0, 0, 0, 0, 0, 0, 2);
      cmp("post_rst_valid", int'(Chk_Valid), 1);
      cmp("post_rst_unchecked", int'(Test_Err), 0);
      // random traffic with occasional corruption, clears and monitor resets
      for (int i = 0; i < 800; i++) begin
         bit rr, orr, en, md, st, cl;
         int v;
         rr  = $urandom_range(0, 99) == 0;
         orr = $urandom_range(0, 9) == 0;
         en  = $urandom_range(0, 3) != 0;
         md  = 1'($urandom_range(0, 1));
         st  = 1'($urandom_range(0, 1));
         cl  = $urandom_range(0, 15) == 0;
         v   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15)) : c;
         cyc(rr, orr, en, md, st, cl, v);
      end
      cyc(0, 0, 0, 0, 0, 0, c);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cnt_monitor.md
Name: cnt_monitor

Overview:
- Synthesizable, cycle-accurate checker that sits at the output end of the decade up/down counter.
- Passively observes the counter's control inputs (Mode, En, Rst, Step) and its 4-bit output Cnt.
- Keeps a reference model of the counter and flags reset, count, range and wrap errors.
- Provides sticky error flags and a saturating error count for on-chip self-test and for benches.

Parameters:
- CNT_W, 4, width of observed count.
- CNT_MAX, 9, highest legal count value; the counter wraps modulo CNT_MAX+1.
- STEP_BIG, 3, increment used when Step=1 (Step=0 uses 1).
- ERRC_W, 8, width of the error counter.

Ports:
- Clk  in  1  system clock; all logic on posedge.
- Rst  in  1  monitor reset; synchronous, active-high.
- Obs_Rst  in  1  observed counter reset (sync, active-high at the counter).
- Obs_En  in  1  observed counter enable.
- Obs_Mode  in  1  observed direction; 1=up, 0=down.
- Obs_Step  in  1  observed step select; 0=1, 1=STEP_BIG.
- Obs_Cnt  in  CNT_W  observed counter output.
- Clear  in  1  clears sticky flags and the error counter (Obs_* tracking unaffected).
- Chk_Valid  out  1  high when the current cycle's comparison is meaningful.
- Reset_Err  out  1  sticky: Cnt != 0 one cycle after Obs_Rst.
- Count_Err  out  1  sticky: Cnt != predicted value in a normal count/hold cycle.
- Range_Err  out  1  sticky: Obs_Cnt > CNT_MAX while Chk_Valid.
- Wrap_Pulse  out  1  one-cycle pulse when the model predicts a wrap (up past CNT_MAX or down past 0).
- Err_Cnt  out  ERRC_W  saturating count of cycles with any mismatch.
- Test_Err  out  1  OR of Reset_Err, Count_Err and Range_Err.

Behaviour:
- Rst=1 at posedge: all outputs 0, internal state to IDLE, prev registers 0. Rst has priority over Clear and over all observation.
- State machine:
  - IDLE: first posedge after Rst deasserts; captures Obs_* and Obs_Cnt into prev registers; Chk_Valid=0. Next state is TRACK.
  - TRACK: every posedge computes a prediction from the prev registers, compares it with the current Obs_Cnt, then recaptures the prev registers.
- Prediction from prev_Rst, prev_En, prev_Mode, prev_Step, prev_Cnt, in priority order:
  - prev_Rst=1: expect 0; a mismatch sets Reset_Err.
  - prev_En=0: expect prev_Cnt (hold).
  - Mode=1: expect (prev_Cnt+s) mod (CNT_MAX+1).
  - Mode=0: expect (prev_Cnt+CNT_MAX+1-s) mod (CNT_MAX+1).
  - s = 1 or STEP_BIG.
  - Non-reset mismatches set Count_Err.
- Arithmetic is done in CNT_W+1 bits to avoid intermediate overflow. prev_Cnt>CNT_MAX makes the prediction undefined: Count_Err is not set that cycle; Range_Err is set instead.
- Chk_Valid=1 in TRACK; comparison results are registered, so flags rise one cycle after the offending Obs_Cnt is sampled.
- Wrap_Pulse is registered with the same timing as the flags. It is asserted when the un-modded sum exceeds CNT_MAX or the down result borrows; it never asserts on reset or hold cycles.
- Err_Cnt increments by 1 per cycle with any mismatch (reset, count or range). It saturates at all-ones and never wraps.
- Clear=1: flags and Err_Cnt go to 0 next cycle. If a mismatch occurs in the same cycle, Clear wins for that cycle and the flag is set on the next mismatch.
- Obs_Rst held several cycles: every cycle expects 0.
- Obs_Rst and Obs_En both high: reset wins.
- Monitor Rst mid-operation: returns to IDLE. The first post-reset cycle is never checked.
- Latency: mismatch at Obs_Cnt sample edge N appears on the flags at edge N+1.

Test Plan:
- Rst, then Obs_En=1, Mode=1, Step=0, correct counter 0..9..0 for 12 cycles -> Chk_Valid=1 from 2nd cycle; Wrap_Pulse once (9->0); all flags 0, Err_Cnt=0.
- Mode=0, Step=1, correct counter from 2: 2->9->6 -> Wrap_Pulse on 2->9 only; no errors.
- Obs_Rst=1 for 2 cycles with Obs_Cnt forced to 5 on the first -> Reset_Err=1, Err_Cnt=1, Test_Err=1; Count_Err=0.
- Obs_En=0 with Obs_Cnt changing 4->5 -> Count_Err=1 next cycle; Clear pulse -> all flags 0, Err_Cnt=0.
- Obs_Cnt=12 injected -> Range_Err=1 next cycle; following cycle no Count_Err from undefined prediction.
- 300 cycles of forced mismatch with ERRC_W=8 -> Err_Cnt stays 255; assert Rst mid-run -> all outputs 0, Chk_Valid=0 for one cycle after release.
